// File: rtl/riscv_hazard_ctrl_if.sv
// Bundle of ID-stage hazard signals exchanged between the pipeline (master) and the hazard
// controller (slave).
//   go          : pipeline run enable
//   id_*        : description of the instruction currently in ID
//   br_taken    : ID resolved a taken branch/jump
//   fwd_sel     : per-operand forwarding select (0 = regfile, k = entry k-1)
//   stall_if_id : hold PC and IF/ID, bubble into EX
//   flush_if_id : squash IF/ID
//   pipe_valid  : valid bit of each tracked post-ID entry
//   stall_count / flush_count : saturating event counters
interface riscv_hazard_ctrl_if #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned NUM_RS = 3,
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned CNT_W  = 16
);
   localparam int unsigned SEL_W = $clog2(DEPTH + 1);

   logic                     go;
   logic                     id_valid;
   logic [NUM_RS*REG_AW-1:0] id_rs_addr;
   logic [NUM_RS-1:0]        id_rs_used;
   logic [REG_AW-1:0]        id_rd_addr;
   logic                     id_rd_we;
   logic                     id_is_load;
   logic                     br_taken;
   logic [NUM_RS*SEL_W-1:0]  fwd_sel;
   logic                     stall_if_id;
   logic                     flush_if_id;
   logic [DEPTH-1:0]         pipe_valid;
   logic [CNT_W-1:0]         stall_count;
   logic [CNT_W-1:0]         flush_count;

   modport master (
      output go, id_valid, id_rs_addr, id_rs_used, id_rd_addr, id_rd_we, id_is_load, br_taken,
      input  fwd_sel, stall_if_id, flush_if_id, pipe_valid, stall_count, flush_count
   );

   modport slave (
      input  go, id_valid, id_rs_addr, id_rs_used, id_rd_addr, id_rd_we, id_is_load, br_taken,
      output fwd_sel, stall_if_id, flush_if_id, pipe_valid, stall_count, flush_count
   );
endinterface

// File: rtl/riscv_hazard_ctrl.sv
// Hazard/forwarding controller for the in-order pipeline. Tracks the destination registers of
// the DEPTH instructions after ID (entry0 = EX), selects forwarding sources for each ID source
// operand, stalls on load-use and flushes IF/ID on taken branches.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : hazard interface (slave side), see riscv_hazard_ctrl_if
module riscv_hazard_ctrl #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned NUM_RS = 3,
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned CNT_W  = 16
) (
   input logic                clk,
   input logic                reset,
   riscv_hazard_ctrl_if.slave bus
);
   localparam int unsigned SEL_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]             valid_q, valid_d;
   logic [DEPTH-1:0]             we_q, we_d;
   logic [DEPTH-1:0]             ld_q, ld_d;
   logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
   logic [CNT_W-1:0]             stall_cnt_q, flush_cnt_q;

   logic [NUM_RS-1:0][SEL_W-1:0] hit_sel;
   logic [NUM_RS-1:0]            load_use;
   logic                         stall;
   logic                         flush;

   // Youngest match per operand: scan oldest to youngest so the lowest entry wins.
   always_comb begin
      hit_sel  = '0;
      load_use = '0;
      for (int i = 0; i < int'(NUM_RS); i++) begin
         if (bus.id_valid && bus.id_rs_used[i] && (bus.id_rs_addr[i*REG_AW +: REG_AW] != '0))
         begin
            for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
               if (valid_q[k] && we_q[k] && (rd_q[k] == bus.id_rs_addr[i*REG_AW +: REG_AW]))
               begin
                  hit_sel[i] = SEL_W'(k + 1);
               end
            end
         end
         load_use[i] = (hit_sel[i] == SEL_W'(1)) && ld_q[0];
      end
   end

   assign stall = bus.go && (|load_use);
   // Gated by reset so a branch seen while the pipeline is held in reset is not acted on.
   assign flush = reset && bus.go && bus.br_taken && !stall;

   always_comb begin
      bus.fwd_sel = '0;
      if (bus.go && !stall) begin
         for (int i = 0; i < int'(NUM_RS); i++) begin
            bus.fwd_sel[i*SEL_W +: SEL_W] = hit_sel[i];
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      we_d    = we_q;
      ld_d    = ld_q;
      rd_d    = rd_q;
      if (bus.go) begin
         for (int k = 1; k < int'(DEPTH); k++) begin
            valid_d[k] = valid_q[k-1];
            we_d[k]    = we_q[k-1];
            ld_d[k]    = ld_q[k-1];
            rd_d[k]    = rd_q[k-1];
         end
         // Stall or flush turns the instruction entering EX into a bubble.
         valid_d[0] = bus.id_valid && !stall && !flush;
         we_d[0]    = bus.id_rd_we;
         ld_d[0]    = bus.id_is_load;
         rd_d[0]    = bus.id_rd_addr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q     <= '0;
         we_q        <= '0;
         ld_q        <= '0;
         rd_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         valid_q <= valid_d;
         we_q    <= we_d;
         ld_q    <= ld_d;
         rd_q    <= rd_d;
         if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.stall_if_id = stall;
   assign bus.flush_if_id = flush;
   assign bus.pipe_valid  = valid_q;
   assign bus.stall_count = stall_cnt_q;
   assign bus.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Bench for riscv_hazard_ctrl: random stimulus checked every cycle against a behavioural model,
// plus directed sequences with literal expectations.
module tb_riscv_hazard_ctrl;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned NUM_RS = 3;
   localparam int unsigned DEPTH  = 3;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned SEL_W  = $clog2(DEPTH + 1);
   localparam int          CMAX   = (1 << CNT_W) - 1;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   riscv_hazard_ctrl_if #(.REG_AW(REG_AW), .NUM_RS(NUM_RS), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   riscv_hazard_ctrl #(.REG_AW(REG_AW), .NUM_RS(NUM_RS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int fsel(input int i);
      return int'(bus.fwd_sel[i*SEL_W +: SEL_W]);
   endfunction

   // Behavioural model: list of in-flight instructions, index 0 = EX.
   typedef struct packed {
      logic             v;
      logic [REG_AW-1:0] rd;
      logic             we;
      logic             ld;
   } ent_t;

   ent_t m  [DEPTH] = '{default: '0};
   ent_t mn [DEPTH] = '{default: '0};
   int   sc = 0, fc = 0, scn = 0, fcn = 0;

   always @(negedge clk) begin
      automatic int  hit [NUM_RS];
      automatic bit  st = 1'b0;
      automatic bit  fl;
      automatic int  rs;
      automatic int  exp_sel;
      if (!reset) begin
         chk("rst_pipe_valid", int'(bus.pipe_valid), 0);
         chk("rst_stall", int'(bus.stall_if_id), 0);
         chk("rst_flush", int'(bus.flush_if_id), 0);
         chk("rst_fwd", int'(bus.fwd_sel), 0);
         chk("rst_stall_count", int'(bus.stall_count), 0);
         chk("rst_flush_count", int'(bus.flush_count), 0);
         mn  <= '{default: '0};
         scn <= 0;
         fcn <= 0;
      end else begin
         for (int i = 0; i < int'(NUM_RS); i++) begin
            hit[i] = -1;
            rs = int'(bus.id_rs_addr[i*REG_AW +: REG_AW]);
            if (bus.id_valid && bus.id_rs_used[i] && rs != 0) begin
               for (int k = 0; k < int'(DEPTH); k++) begin
                  if (hit[i] < 0 && m[k].v && m[k].we && int'(m[k].rd) == rs) hit[i] = k;
               end
            end
            if (bus.go && hit[i] == 0 && m[0].ld) st = 1'b1;
         end
         fl = bus.go && bus.br_taken && !st;
         chk("stall", int'(bus.stall_if_id), int'(st));
         chk("flush", int'(bus.flush_if_id), int'(fl));
         for (int i = 0; i < int'(NUM_RS); i++) begin
            exp_sel = (bus.go && !st && hit[i] >= 0) ? hit[i] + 1 : 0;
            chk("fwd_sel", fsel(i), exp_sel);
         end
         for (int k = 0; k < int'(DEPTH); k++) chk("pipe_valid", int'(bus.pipe_valid[k]), int'(m[k].v));
         chk("stall_count", int'(bus.stall_count), sc);
         chk("flush_count", int'(bus.flush_count), fc);
         if (bus.go) begin
            for (int k = 1; k < int'(DEPTH); k++) mn[k] <= m[k-1];
            mn[0] <= '{v: bus.id_valid && !st && !fl, rd: bus.id_rd_addr,
                       we: bus.id_rd_we, ld: bus.id_is_load};
            scn <= st ? ((sc + 1 > CMAX) ? CMAX : sc + 1) : sc;
            fcn <= fl ? ((fc + 1 > CMAX) ? CMAX : fc + 1) : fc;
         end else begin
            mn  <= m;
            scn <= sc;
            fcn <= fc;
         end
      end
   end

   always @(posedge clk) begin
      m  <= mn;
      sc <= scn;
      fc <= fcn;
   end

   task automatic ins(input bit v, input int r0, input int r1, input int r2, input int used,
                      input int rd, input bit we, input bit ld, input bit br);
      bus.id_valid   = v;
      bus.id_rs_addr = {REG_AW'(r2), REG_AW'(r1), REG_AW'(r0)};
      bus.id_rs_used = NUM_RS'(used);
      bus.id_rd_addr = REG_AW'(rd);
      bus.id_rd_we   = we;
      bus.id_is_load = ld;
      bus.br_taken   = br;
   endtask

   task automatic step(input bit v, input int r0, input int r1, input int r2, input int used,
                       input int rd, input bit we, input bit ld, input bit br);
      @(posedge clk);
      #1;
      ins(v, r0, r1, r2, used, rd, we, ld, br);
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rand_phase(input int n);
      for (int j = 0; j < n; j++) begin
         @(posedge clk);
         #1;
         bus.go = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 99) == 0) reset = 1'b0;
         else reset = 1'b1;
         ins(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset  = 1'b0;
      bus.go = 1'b0;
      ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      rand_phase(300);

      // Mid-stream reset: everything clears in the same cycle, even with a branch pending.
      @(posedge clk);
      #1;
      bus.go = 1'b1;
      ins(1, 1, 2, 3, 7, 4, 1, 0, 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_pipe_valid", int'(bus.pipe_valid), 0);
      chk("mid_rst_flush", int'(bus.flush_if_id), 0);
      chk("mid_rst_stall_count", int'(bus.stall_count), 0);
      chk("mid_rst_flush_count", int'(bus.flush_count), 0);
      @(posedge clk);
      #1;
      bus.go = 1'b0;
      reset  = 1'b1;
      for (int j = 0; j < 3; j++) begin
         step(1, 1, 2, 0, 3, 5, 1, 0, 0);
         @(negedge clk);
         chk("hold_pipe_valid", int'(bus.pipe_valid), 0);
         chk("hold_fwd", int'(bus.fwd_sel), 0);
      end

      // EX/MEM/WB forwarding.
      @(posedge clk);
      #1;
      bus.go = 1'b1;
      ins(1, 1, 2, 0, 3, 5, 1, 0, 0);
      step(1, 5, 3, 0, 3, 6, 1, 0, 0);
      @(negedge clk);
      chk("fwd_ex", fsel(0), 1);
      chk("fwd_ex_op1", fsel(1), 0);
      step(1, 5, 0, 0, 1, 10, 1, 0, 0);
      @(negedge clk);
      chk("fwd_mem", fsel(0), 2);
      step(1, 5, 0, 0, 1, 11, 1, 0, 0);
      @(negedge clk);
      chk("fwd_wb", fsel(0), 3);
      step(1, 5, 0, 0, 1, 12, 1, 0, 0);
      @(negedge clk);
      chk("fwd_gone", fsel(0), 0);
      idle(3);

      // Youngest wins; x0 never forwards.
      step(1, 0, 0, 0, 1, 7, 1, 0, 0);
      step(1, 0, 0, 0, 1, 7, 1, 0, 0);
      step(1, 7, 0, 0, 1, 12, 1, 0, 0);
      @(negedge clk);
      chk("fwd_youngest", fsel(0), 1);
      step(1, 1, 0, 0, 1, 0, 1, 0, 0);
      step(1, 0, 0, 0, 1, 13, 1, 0, 0);
      @(negedge clk);
      chk("fwd_x0", fsel(0), 0);
      idle(3);

      // Load-use: one stall cycle, bubble in EX, then forward from MEM.
      step(1, 1, 0, 0, 1, 8, 1, 1, 0);
      step(1, 8, 8, 0, 3, 9, 1, 0, 0);
      @(negedge clk);
      chk("lu_stall", int'(bus.stall_if_id), 1);
      chk("lu_fwd0_zero", fsel(0), 0);
      chk("lu_fwd1_zero", fsel(1), 0);
      step(1, 8, 8, 0, 3, 9, 1, 0, 0);
      @(negedge clk);
      chk("lu_stall_done", int'(bus.stall_if_id), 0);
      chk("lu_fwd0", fsel(0), 2);
      chk("lu_fwd1", fsel(1), 2);
      chk("lu_pipe_valid", int'(bus.pipe_valid), 2);
      chk("lu_stall_count", int'(bus.stall_count), 1);
      idle(3);

      // Branch flush with no hazard.
      step(1, 1, 2, 0, 3, 0, 0, 0, 1);
      @(negedge clk);
      chk("br_flush", int'(bus.flush_if_id), 1);
      chk("br_flush_count_pre", int'(bus.flush_count), 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("br_flush_off", int'(bus.flush_if_id), 0);
      chk("br_pipe_valid", int'(bus.pipe_valid), 0);
      chk("br_flush_count", int'(bus.flush_count), 1);

      // Branch during a load-use stall is ignored.
      step(1, 1, 0, 0, 1, 8, 1, 1, 0);
      step(1, 8, 8, 0, 3, 9, 1, 0, 1);
      @(negedge clk);
      chk("brst_stall", int'(bus.stall_if_id), 1);
      chk("brst_flush", int'(bus.flush_if_id), 0);
      step(1, 8, 8, 0, 3, 9, 1, 0, 0);
      @(negedge clk);
      chk("brst_stall_count", int'(bus.stall_count), 2);
      chk("brst_flush_count", int'(bus.flush_count), 1);
      idle(3);

      // Repeated lw x8,0(x8) stalls every other cycle; counter must saturate.
      for (int j = 0; j < 40; j++) step(1, 8, 0, 0, 1, 8, 1, 1, 0);
      @(negedge clk);
      chk("sat_stall_count", int'(bus.stall_count), CMAX);

      // Drop go: outputs forced off, state frozen.
      @(posedge clk);
      #1;
      bus.go = 1'b0;
      ins(1, 8, 0, 0, 1, 9, 1, 0, 1);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("nogo_stall", int'(bus.stall_if_id), 0);
         chk("nogo_flush", int'(bus.flush_if_id), 0);
         chk("nogo_fwd", fsel(0), 0);
         chk("nogo_stall_count", int'(bus.stall_count), CMAX);
         chk("nogo_flush_count", int'(bus.flush_count), 1);
      end

      rand_phase(300);
      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
